pixel_stream_tx: RTL and testbench

Frame transmitter. Reads one IMG_SIZE x IMG_SIZE greyscale frame from a synchronous-read image RAM in raster order and streams it as 8-bit pixels with valid/ready handshake. Sits upstream of the 3x3 convolution engine, driving its pixel input and valid_in. It is the source end of the pixel stream that the convolver consumes. Start/busy/done control comes from the top-level sequencer.

---
 rtl/pixel_tx_pkg.sv | 18 +
 rtl/pixel_skid_buf.sv | 47 ++++
 rtl/pixel_stream_tx.sv | 143 ++++++++++++++
 tb/tb_pixel_stream_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_tx_pkg.sv
// Shared types and helpers for the pixel frame transmitter.
package pixel_tx_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} tx_state_e;

  localparam int IMG_SIZE_DEF = 100;
  localparam int FRAME_BEATS  = IMG_SIZE_DEF * IMG_SIZE_DEF;

  // Bits needed to hold the values 0..n-1 (never less than one).
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int frame_beats(input int img);
    return img * img;
  endfunction

endpackage

// File: rtl/pixel_skid_buf.sv
// Two-entry fall-through valid/ready buffer: an arriving word is visible the
// same cycle when empty, and is parked when the consumer stalls.
module pixel_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            count
);
  import pixel_tx_pkg::*;

  logic [DATA_WIDTH-1:0] ent0, ent1, lst0, lst1, ent0_nx, ent1_nx;
  logic                  push, pop;
  logic [1:0]            count_nx;

  assign push      = in_valid && (count != 2'd2);
  assign out_valid = (count != 2'd0) || in_valid;
  assign out_data  = (count != 2'd0) ? ent0 : (in_valid ? in_data : '0);
  assign pop       = out_valid && out_ready;

  // Ordered view {ent0, ent1, in_data}; a pop shifts the view down one slot.
  always_comb begin
    lst0     = (count != 2'd0) ? ent0 : in_data;
    lst1     = (count >  2'd1) ? ent1 : in_data;
    ent0_nx  = pop ? lst1 : lst0;
    ent1_nx  = pop ? in_data : lst1;
    count_nx = count + 2'(push) - 2'(pop);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      count <= count_nx;
      ent0  <= ent0_nx;
      ent1  <= ent1_nx;
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame transmitter: raster-order reads from a sync-read image RAM, streamed out
// with valid/ready. Define PIXEL_TX_GAP_EN to insert ROW_GAP idle cycles per row.
module pixel_stream_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_SIZE   = 100,
  parameter int ADDR_WIDTH = 14,
  parameter int BASE_ADDR  = 0,
  parameter int ROW_GAP    = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic                  ready_in,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  busy,
  output logic                  done
);
  import pixel_tx_pkg::*;

  localparam int                    BEATS      = frame_beats(IMG_SIZE);
  localparam int                    CW         = width_for(IMG_SIZE);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BASE_ADDR + BEATS - 1);
  localparam logic [CW-1:0]         EDGE       = CW'(IMG_SIZE - 1);

  if (BASE_ADDR + BEATS > (1 << ADDR_WIDTH)) begin : g_addr_chk
    $error("pixel_stream_tx: ADDR_WIDTH cannot reach the last pixel");
  end
  if (ROW_GAP < 0) begin : g_gap_chk
    $error("pixel_stream_tx: ROW_GAP must be non-negative");
  end

  tx_state_e     state, state_nx;
  logic          rd_pend, beat_acc, row_end, last_beat, issue_ok;
  logic [1:0]    buf_cnt;
  logic [CW-1:0] col, row;

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = STREAM;
      STREAM:  if (mem_rd_en && mem_addr == LAST_ADDR) state_nx = DRAIN;
      DRAIN:   if (last_beat) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Issue only if the word landing next cycle fits: parked + in-flight <= 1.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    case (state)
      STREAM: begin
        busy      = 1'b1;
        mem_rd_en = issue_ok && ((buf_cnt + 2'(rd_pend)) <= 2'd1);
      end
      DRAIN:   busy = 1'b1;
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem_addr <= FIRST_ADDR;
      rd_pend  <= 1'b0;
    end else begin
      rd_pend <= mem_rd_en;
      if (state == IDLE || state == FINISH) mem_addr <= FIRST_ADDR;
      else if (mem_rd_en)                   mem_addr <= mem_addr + ADDR_WIDTH'(1);
    end
  end

  pixel_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (rd_pend),
    .in_data   (mem_data),
    .out_valid (valid_out),
    .out_data  (data_out),
    .out_ready (ready_in),
    .count     (buf_cnt)
  );

  assign beat_acc  = valid_out && ready_in;
  assign row_end   = beat_acc && (col == EDGE);
  assign last_beat = row_end && (row == EDGE);

  always_ff @(posedge Clk) begin
    if (Rst || state == IDLE) begin
      col <= '0;
      row <= '0;
    end else if (beat_acc) begin
      if (col == EDGE) begin
        col <= '0;
        row <= row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

`ifdef PIXEL_TX_GAP_EN
  localparam int GW = width_for(ROW_GAP + 2);

  logic [CW-1:0] rd_col;
  logic [GW-1:0] gap_cnt;
  logic          gap_hold, row_issued;

  // After a row's last read, hold issue until its last beat leaves and the
  // gap has run; release one cycle early so the RAM latency fills the slot.
  assign row_issued = mem_rd_en && (rd_col == EDGE) && (mem_addr != LAST_ADDR);
  assign issue_ok   = !gap_hold || (gap_cnt == GW'(1)) || ((ROW_GAP == 0) && row_end);

  always_ff @(posedge Clk) begin
    if (Rst || state == IDLE) begin
      rd_col   <= '0;
      gap_hold <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      if (mem_rd_en) rd_col <= (rd_col == EDGE) ? '0 : rd_col + CW'(1);
      if (row_issued)     gap_hold <= 1'b1;
      else if (mem_rd_en) gap_hold <= 1'b0;
      if (row_end && !last_beat)  gap_cnt <= GW'(ROW_GAP);
      else if (gap_cnt != '0)     gap_cnt <= gap_cnt - GW'(1);
    end
  end
`else
  assign issue_ok = 1'b1;
`endif

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: cycle table for one frame plus scoreboarded corner sequences.
module tb_pixel_stream_tx;
  localparam int DW = 8, IMG = 4, AW = 6, BASE = 0, GAP = 2, BEATS = IMG * IMG;
`ifdef PIXEL_TX_GAP_EN
  localparam int GAPS = GAP;
`else
  localparam int GAPS = 0;
`endif
  localparam int DCYC = BEATS + 2 + GAPS * (IMG - 1);
  localparam int TLEN = DCYC + 2;

  logic          Clk = 1'b0, Rst = 1'b1, start = 1'b0, ready_in = 1'b0;
  logic          mem_rd_en, valid_out, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data = '0, data_out;

  pixel_stream_tx #(.DATA_WIDTH(DW), .IMG_SIZE(IMG), .ADDR_WIDTH(AW),
                    .BASE_ADDR(BASE), .ROW_GAP(GAP)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .ready_in(ready_in),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .data_out(data_out), .valid_out(valid_out), .busy(busy), .done(done));

  always #5 Clk = ~Clk;

  // RAM[a] = a - BASE, one-cycle read latency
  always @(posedge Clk) if (mem_rd_en) mem_data <= DW'(mem_addr - AW'(BASE));

  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard and monitor
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  int done_cnt = 0, beat_cnt = 0, issued = 0, accepted = 0;

  always @(negedge Clk) begin
    if (mem_rd_en) chk("rd_room", (issued - accepted) <= 1, 1);
    if (valid_out && ready_in) begin
      beat_cnt++;
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        chk("beat_data", data_out, mon_exp);
      end
    end
    if (done) done_cnt++;
    if (mem_rd_en) issued++;
    if (valid_out && ready_in) accepted++;
    if (Rst) begin
      issued = 0;
      accepted = 0;
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic push_frame;
    for (int k = 0; k < BEATS; k++) exp_q.push_back(DW'(k));
  endtask

  task automatic wait_done(input int budget, input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge Clk);
      if (done) seen = 1'b1;
      tick();
    end
    chk({nm, "_done_seen"}, seen, 1);
  endtask

  typedef struct {
    logic          start;
    logic          ready;
    logic          valid;
    logic [DW-1:0] data;
    logic          busy;
    logic          done;
    logic          rd;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl[TLEN];

  initial begin
    int d0, b0, bc;
    logic found;

    for (int c = 0; c < TLEN; c++)
      tbl[c] = '{start: (c == 0), ready: 1'b1, valid: 1'b0, data: '0,
                 busy: (c >= 1 && c < DCYC), done: (c == DCYC), rd: 1'b0, addr: '0};
    for (int k = 0; k < BEATS; k++) begin
      bc = 2 + k + GAPS * (k / IMG);
      tbl[bc].valid    = 1'b1;
      tbl[bc].data     = DW'(k);
      tbl[bc - 1].rd   = 1'b1;
      tbl[bc - 1].addr = AW'(BASE + k);
    end

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, BASE);
    tick();
    Rst = 1'b0;

    // Basic frame, cycle-accurate
    for (int c = 0; c < TLEN; c++) begin
      start = tbl[c].start;
      ready_in = tbl[c].ready;
      if (c == 0) push_frame();
      @(negedge Clk);
      chk($sformatf("tbl%0d_valid", c), valid_out, tbl[c].valid);
      if (tbl[c].valid) chk($sformatf("tbl%0d_data", c), data_out, tbl[c].data);
      chk($sformatf("tbl%0d_busy", c), busy, tbl[c].busy);
      chk($sformatf("tbl%0d_done", c), done, tbl[c].done);
      chk($sformatf("tbl%0d_rd_en", c), mem_rd_en, tbl[c].rd);
      if (tbl[c].rd) chk($sformatf("tbl%0d_addr", c), mem_addr, tbl[c].addr);
      tick();
    end
    start = 1'b0;
    chk("tbl_done_count", done_cnt, 1);
    chk("tbl_q_empty", exp_q.size(), 0);

    // Backpressure while pixel 5 is presented
    d0 = done_cnt; b0 = beat_cnt;
    start = 1'b1; push_frame(); tick(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge Clk);
      if (valid_out && data_out == 4) found = 1'b1;
      tick();
    end
    chk("bp_found4", found, 1);
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("bp_hold_valid", valid_out, 1);
      chk("bp_hold_data", data_out, 5);
      tick();
    end
    ready_in = 1'b1;
    wait_done(80, "bp");
    chk("bp_beats", beat_cnt - b0, BEATS);
    chk("bp_done_count", done_cnt - d0, 1);
    chk("bp_q_empty", exp_q.size(), 0);

    // Random ready, several frames
    for (int f = 0; f < 4; f++) begin
      logic seen;
      d0 = done_cnt; b0 = beat_cnt;
      start = 1'b1; push_frame(); tick(); start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
        ready_in = 1'($urandom_range(0, 1));
        @(negedge Clk);
        if (done) seen = 1'b1;
        tick();
      end
      chk($sformatf("rnd%0d_done_seen", f), seen, 1);
      chk($sformatf("rnd%0d_beats", f), beat_cnt - b0, BEATS);
      chk($sformatf("rnd%0d_done_count", f), done_cnt - d0, 1);
      chk($sformatf("rnd%0d_q_empty", f), exp_q.size(), 0);
    end
    ready_in = 1'b1;

    // Reset after beat 7 (start held with Rst: reset must win)
    d0 = done_cnt; b0 = beat_cnt;
    start = 1'b1; push_frame(); tick(); start = 1'b0;
    for (int i = 0; i < 60 && (beat_cnt - b0) < 8; i++) begin
      @(negedge Clk);
      tick();
    end
    chk("mid_reached8", beat_cnt - b0, 8);
    Rst = 1'b1; start = 1'b1; ready_in = 1'b0;
    tick();
    Rst = 1'b0; start = 1'b0;
    @(negedge Clk);
    chk("mid_valid", valid_out, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    tick();
    exp_q.delete();
    ready_in = 1'b1;
    repeat (4) tick();
    chk("mid_no_done", done_cnt - d0, 0);
    b0 = beat_cnt;
    start = 1'b1; push_frame(); tick(); start = 1'b0;
    wait_done(80, "restart");
    chk("restart_beats", beat_cnt - b0, BEATS);
    chk("restart_done_count", done_cnt - d0, 1);
    chk("restart_q_empty", exp_q.size(), 0);

    // Second start while busy is ignored
    d0 = done_cnt; b0 = beat_cnt;
    start = 1'b1; push_frame(); tick(); start = 1'b0;
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(80, "ign");
    repeat (4) tick();
    @(negedge Clk);
    chk("ign_busy_after", busy, 0);
    chk("ign_beats", beat_cnt - b0, BEATS);
    chk("ign_done_count", done_cnt - d0, 1);
    chk("ign_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
